// File: rtl/ahb3lite_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg / ahb3lite_cmd_master
//
// AHB3-Lite initiator that turns a simple valid/ready command interface into
// single (non-burst) AHB3-Lite transfers. Address and data phases are
// pipelined, so a new command can be accepted in the same cycle the bus takes
// the previous address. A two-cycle ERROR response cancels the pending
// address phase, reports the error, and reissues the cancelled transfer.
//
// Ports
//   HRESETn, HCLK      : asynchronous active-low reset, rising-edge clock
//   HADDR..HMASTLOCK   : AHB3-Lite address/control outputs (registered)
//   HWDATA             : write data, valid during the data phase
//   HRDATA/HREADY/HRESP: AHB3-Lite slave response inputs
//   cmd_*              : command request (valid/ready handshake)
//   rsp_*              : one-cycle completion pulse with read data / error
// ---------------------------------------------------------------------------
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE      = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ    = 2'b10;
  localparam logic [2:0] HBURST_SINGLE    = 3'b000;
  localparam logic [3:0] HPROT_DATA       = 4'b0001;
  localparam logic [3:0] HPROT_PRIVILEGED = 4'b0010;
  localparam logic       HRESP_ERROR      = 1'b1;
endpackage

module ahb3lite_cmd_master
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  // AHB3-Lite master interface
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  // Command interface
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,
  // Response interface
  output logic                  rsp_valid,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err
);

  // Cancel FSM: RUN is normal operation, CANCEL covers the second cycle of a
  // two-cycle ERROR response.
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_CANCEL = 1'b1;

  logic [0:0]            state;

  // Address-phase register; HADDR/HWRITE/HSIZE are its visible fields.
  logic                  a_valid;
  logic [HDATA_SIZE-1:0] a_wdata;

  // Data-phase register; HWDATA is its visible field.
  logic                  d_valid;
  logic                  d_write;

  logic                  cancel;
  logic                  addr_accept;
  logic                  cmd_load;
  logic                  data_done;

  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA | HPROT_PRIVILEGED;
  assign HMASTLOCK = 1'b0;

  assign cancel = (state == ST_CANCEL);

  // HTRANS is a pure decode of two flops, so it changes only after a clock
  // edge (or asynchronously on reset) and is stable while HREADY is low.
  // Forcing IDLE during CANCEL is what keeps the HREADY=1 of the second error
  // cycle from being taken as an address acceptance.
  assign HTRANS      = (a_valid && !cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign addr_accept = HREADY && (HTRANS == HTRANS_NONSEQ);
  assign cmd_ready   = !cancel && (!a_valid || addr_accept);
  assign cmd_load    = cmd_valid && cmd_ready;
  assign data_done   = d_valid && HREADY;

  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample the pre-edge values and the order of statements does not matter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          // First ERROR cycle: the slave holds HREADY low with HRESP set.
          if (d_valid && (HRESP == HRESP_ERROR) && !HREADY) state <= ST_CANCEL;
        end
        ST_CANCEL: begin
          if (HREADY) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Address phase. Loading a new command takes priority over clearing on
  // acceptance so that back-to-back commands keep the pipe full. During
  // CANCEL the register is simply left alone and is reissued afterwards.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      HADDR   <= '0;
      HWRITE  <= 1'b0;
      HSIZE   <= 3'b000;
      a_wdata <= '0;
    end else if (cmd_load) begin
      a_valid <= 1'b1;
      HADDR   <= cmd_addr;
      HWRITE  <= cmd_write;
      HSIZE   <= cmd_size;
      a_wdata <= cmd_wdata;
    end else if (addr_accept) begin
      a_valid <= 1'b0;
    end
  end

  // Data phase. HWDATA holds its last value once the phase ends.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      HWDATA  <= '0;
    end else if (addr_accept) begin
      d_valid <= 1'b1;
      d_write <= HWRITE;
      HWDATA  <= a_wdata;
    end else if (HREADY) begin
      d_valid <= 1'b0;
    end
  end

  // Completion: one pulse per transfer, in bus order. A single-cycle ERROR
  // (HREADY=1 with HRESP=1) lands here too and is reported without cancel.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= data_done;
      if (data_done) begin
        rsp_err   <= HRESP;
        rsp_rdata <= d_write ? '0 : HRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_cmd_master
//
// Directed bench for ahb3lite_cmd_master. Each table record is one clock
// cycle: the inputs driven during the cycle and the outputs expected in that
// same cycle (sampled on the falling edge). Address/control is compared only
// when NONSEQ is expected, response payload only when rsp_valid is expected,
// HWDATA only where the record asks for it. The reset-during-transfer case is
// a hand-written sequence after the table.
// ---------------------------------------------------------------------------
module tb_ahb3lite_cmd_master;
  import ahb3lite_pkg::*;

  logic        HRESETn;
  logic        HCLK;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  ahb3lite_cmd_master #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HRESETn   (HRESETn),
    .HCLK      (HCLK),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    // inputs for this cycle
    bit          cv;
    bit          cw;
    logic [31:0] ca;
    logic [2:0]  cs;
    logic [31:0] cd;
    bit          rdy;
    bit          resp;
    logic [31:0] rd;
    // expected outputs in this cycle
    bit          ns;
    logic [31:0] ea;
    bit          ew;
    logic [2:0]  es;
    bit          wchk;
    logic [31:0] ewd;
    bit          cr;
    bit          rv;
    bit          re;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input string n, input bit cv, input bit cw, input logic [31:0] ca,
    input logic [2:0] cs, input logic [31:0] cd, input bit rdy, input bit resp,
    input logic [31:0] rd, input bit ns, input logic [31:0] ea, input bit ew,
    input logic [2:0] es, input bit wchk, input logic [31:0] ewd, input bit cr,
    input bit rv, input bit re, input logic [31:0] erd);
    vec_t v;
    v.name = n;  v.cv = cv;  v.cw = cw;  v.ca = ca;  v.cs = cs;  v.cd = cd;
    v.rdy = rdy; v.resp = resp; v.rd = rd;
    v.ns = ns;   v.ea = ea;  v.ew = ew;  v.es = es;  v.wchk = wchk; v.ewd = ewd;
    v.cr = cr;   v.rv = rv;  v.re = re;  v.erd = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit cv, input bit cw, input logic [31:0] ca, input logic [2:0] cs,
                       input logic [31:0] cd, input bit rdy, input bit resp, input logic [31:0] rd);
    cmd_valid = cv;  cmd_write = cw;  cmd_addr = ca;  cmd_size = cs;  cmd_wdata = cd;
    HREADY    = rdy; HRESP     = resp; HRDATA = rd;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.cv, v.cw, v.ca, v.cs, v.cd, v.rdy, v.resp, v.rd);
    @(negedge HCLK);
    check({v.name, ".htrans"}, {30'd0, HTRANS}, {30'd0, v.ns ? HTRANS_NONSEQ : HTRANS_IDLE});
    if (v.ns) begin
      check({v.name, ".haddr"}, HADDR, v.ea);
      check({v.name, ".hwrite"}, {31'd0, HWRITE}, {31'd0, v.ew});
      check({v.name, ".hsize"}, {29'd0, HSIZE}, {29'd0, v.es});
    end
    if (v.wchk) check({v.name, ".hwdata"}, HWDATA, v.ewd);
    check({v.name, ".cmd_ready"}, {31'd0, cmd_ready}, {31'd0, v.cr});
    check({v.name, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v.rv});
    if (v.rv) begin
      check({v.name, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, v.re});
      check({v.name, ".rsp_rdata"}, rsp_rdata, v.erd);
    end
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    //          name      cv cw ca            cs   cd            rdy rsp rd             ns ea            ew es   wc ewd           cr rv re erd
    // 1: idle bus
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk("idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // 2: zero-wait write
    tbl.push_back(mk("wr.c0", 1, 1, 32'h100, 3'd2, 32'hDEADBEEF, 1, 0, 0,  0, 0, 0, 0,            0, 0,            1, 0, 0, 0));
    tbl.push_back(mk("wr.c1", 0, 0, 0, 0, 0,                     1, 0, 0,  1, 32'h100, 1, 3'd2, 0, 0,            1, 0, 0, 0));
    tbl.push_back(mk("wr.c2", 0, 0, 0, 0, 0,                     1, 0, 0,  0, 0, 0, 0,            1, 32'hDEADBEEF, 1, 0, 0, 0));
    tbl.push_back(mk("wr.c3", 0, 0, 0, 0, 0,                     1, 0, 0,  0, 0, 0, 0,            0, 0,            1, 1, 0, 0));
    // 3: two reads, first has two wait states
    tbl.push_back(mk("rd.c0", 1, 0, 32'h0, 3'd1, 0, 1, 0, 0,            0, 0, 0, 0,          0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("rd.c1", 1, 0, 32'h4, 3'd1, 0, 1, 0, 0,            1, 32'h0, 0, 3'd1,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("rd.c2", 0, 0, 0, 0, 0,        0, 0, 32'hFFFFFFFF, 1, 32'h4, 0, 3'd1,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rd.c3", 0, 0, 0, 0, 0,        0, 0, 32'hFFFFFFFF, 1, 32'h4, 0, 3'd1,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rd.c4", 0, 0, 0, 0, 0,        1, 0, 32'hA5A50000, 1, 32'h4, 0, 3'd1,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("rd.c5", 0, 0, 0, 0, 0,        1, 0, 32'h12345678, 0, 0, 0, 0,          0, 0, 1, 1, 0, 32'hA5A50000));
    tbl.push_back(mk("rd.c6", 0, 0, 0, 0, 0,        1, 0, 0,            0, 0, 0, 0,          0, 0, 1, 1, 0, 32'h12345678));
    tbl.push_back(mk("rd.c7", 0, 0, 0, 0, 0,        1, 0, 0,            0, 0, 0, 0,          0, 0, 1, 0, 0, 0));
    // 4: two-cycle ERROR with a read pending -> cancel and reissue
    tbl.push_back(mk("er.c0", 1, 0, 32'h80000000, 3'd2, 0, 1, 0, 0,     0, 0, 0, 0,              0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("er.c1", 1, 0, 32'h0, 3'd2, 0,        1, 0, 0,     1, 32'h80000000, 0, 3'd2, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("er.c2", 0, 0, 0, 0, 0,               0, 1, 0,     1, 32'h0, 0, 3'd2,        0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("er.c3", 0, 0, 0, 0, 0,               1, 1, 32'h0000EEEE, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("er.c4", 0, 0, 0, 0, 0,               1, 0, 0,     1, 32'h0, 0, 3'd2,        0, 0, 1, 1, 1, 32'h0000EEEE));
    tbl.push_back(mk("er.c5", 0, 0, 0, 0, 0,               1, 0, 32'hC0DE0004, 0, 0, 0, 0,       0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("er.c6", 0, 0, 0, 0, 0,               1, 0, 0,     0, 0, 0, 0,               0, 0, 1, 1, 0, 32'hC0DE0004));
    tbl.push_back(mk("er.c7", 0, 0, 0, 0, 0,               1, 0, 0,     0, 0, 0, 0,               0, 0, 1, 0, 0, 0));
    // 6: two-cycle ERROR with nothing pending -> cmd_ready low for one cycle
    tbl.push_back(mk("en.c0", 1, 1, 32'h80000010, 3'd2, 32'h11112222, 1, 0, 0, 0, 0, 0, 0,              0, 0,            1, 0, 0, 0));
    tbl.push_back(mk("en.c1", 0, 0, 0, 0, 0,                          1, 0, 0, 1, 32'h80000010, 1, 3'd2, 0, 0,            1, 0, 0, 0));
    tbl.push_back(mk("en.c2", 0, 0, 0, 0, 0,                          0, 1, 0, 0, 0, 0, 0,              1, 32'h11112222, 1, 0, 0, 0));
    tbl.push_back(mk("en.c3", 0, 0, 0, 0, 0,                          1, 1, 0, 0, 0, 0, 0,              1, 32'h11112222, 0, 0, 0, 0));
    tbl.push_back(mk("en.c4", 0, 0, 0, 0, 0,                          1, 0, 0, 0, 0, 0, 0,              0, 0,            1, 1, 1, 0));
    tbl.push_back(mk("en.c5", 0, 0, 0, 0, 0,                          1, 0, 0, 0, 0, 0, 0,              0, 0,            1, 0, 0, 0));
    // Single-cycle ERROR (HREADY=1): reported, no cancel
    tbl.push_back(mk("e1.c0", 1, 1, 32'h20, 3'd0, 32'h55, 1, 0, 0, 0, 0, 0, 0,         0, 0,      1, 0, 0, 0));
    tbl.push_back(mk("e1.c1", 0, 0, 0, 0, 0,              1, 0, 0, 1, 32'h20, 1, 3'd0, 0, 0,      1, 0, 0, 0));
    tbl.push_back(mk("e1.c2", 0, 0, 0, 0, 0,              1, 1, 0, 0, 0, 0, 0,         1, 32'h55, 1, 0, 0, 0));
    tbl.push_back(mk("e1.c3", 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0,         0, 0,      1, 1, 1, 0));
    tbl.push_back(mk("e1.c4", 0, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0,         0, 0,      1, 0, 0, 0));
    // Back-to-back writes: load and accept in the same cycle
    tbl.push_back(mk("bb.c0", 1, 1, 32'h40, 3'd2, 32'h40404040, 1, 0, 0, 0, 0, 0, 0,         0, 0,            1, 0, 0, 0));
    tbl.push_back(mk("bb.c1", 1, 1, 32'h44, 3'd2, 32'h44444444, 1, 0, 0, 1, 32'h40, 1, 3'd2, 0, 0,            1, 0, 0, 0));
    tbl.push_back(mk("bb.c2", 0, 0, 0, 0, 0,                    1, 0, 0, 1, 32'h44, 1, 3'd2, 1, 32'h40404040, 1, 0, 0, 0));
    tbl.push_back(mk("bb.c3", 0, 0, 0, 0, 0,                    1, 0, 0, 0, 0, 0, 0,         1, 32'h44444444, 1, 1, 0, 0));
    tbl.push_back(mk("bb.c4", 0, 0, 0, 0, 0,                    1, 0, 0, 0, 0, 0, 0,         0, 0,            1, 1, 0, 0));
    tbl.push_back(mk("bb.c5", 0, 0, 0, 0, 0,                    1, 0, 0, 0, 0, 0, 0,         0, 0,            1, 0, 0, 0));

    // Reset values, observed while reset is held
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst.htrans",    {30'd0, HTRANS},    {30'd0, HTRANS_IDLE});
    check("rst.haddr",     HADDR,              32'h0);
    check("rst.hwrite",    {31'd0, HWRITE},    32'h0);
    check("rst.hsize",     {29'd0, HSIZE},     32'h0);
    check("rst.hwdata",    HWDATA,             32'h0);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'h0);
    check("rst.rsp_rdata", rsp_rdata,          32'h0);
    check("rst.rsp_err",   {31'd0, rsp_err},   32'h0);
    check("rst.cmd_ready", {31'd0, cmd_ready}, 32'h1);
    check("rst.hburst",    {29'd0, HBURST},    32'h0);
    check("rst.hprot",     {28'd0, HPROT},     32'h3);
    check("rst.hmastlock", {31'd0, HMASTLOCK}, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // 5: reset during a wait-stated write with a second write queued
    drive(1, 1, 32'h200, 3'd2, 32'h22222222, 1, 0, 0);
    @(posedge HCLK); #1;
    drive(1, 1, 32'h204, 3'd2, 32'h24242424, 1, 0, 0);
    @(posedge HCLK); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("mr.pre.htrans", {30'd0, HTRANS}, {30'd0, HTRANS_NONSEQ});
    check("mr.pre.haddr",  HADDR, 32'h204);
    #2 HRESETn = 1'b0;
    #1;
    check("mr.in.htrans", {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
    HREADY = 1'b1;
    repeat (2) begin
      @(negedge HCLK);
      check("mr.in.rsp_valid", {31'd0, rsp_valid}, 32'h0);
    end
    HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      check("mr.post.rsp_valid", {31'd0, rsp_valid}, 32'h0);
      check("mr.post.htrans",    {30'd0, HTRANS},    {30'd0, HTRANS_IDLE});
      check("mr.post.cmd_ready", {31'd0, cmd_ready}, 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
